branch_pht: RTL and testbench

- Parametrised pattern history table: array of ENTRIES saturating up/down counters of CTR_WIDTH bits, indexed by fetch PC.
- Optional gshare mode XORs the index with a global history register (GHR).
- Sits beside fetch: lookup in the fetch stage, prediction registered one cycle later; resolved branches update from execute.
- Generalises the single 2-bit predictor counter to a full table with history and a configurable width and reset value.

---
 rtl/branch_pht.sv | 122 ++++++++++++
 tb/tb_branch_pht.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_pht.sv
// rtl/branch_pht.sv - pattern history table of saturating counters with optional gshare indexing
module branch_pht #(
  parameter int PC_WIDTH   = 32,
  parameter int ENTRIES    = 64,
  parameter int CTR_WIDTH  = 2,
  parameter int INIT_VALUE = 1,
  parameter int GSHARE     = 1,
  parameter int GHR_WIDTH  = 6,
  localparam int IDX_BITS  = $clog2(ENTRIES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lookup_valid,
  input  logic [PC_WIDTH-1:0]  lookup_pc,
  output logic                 pred_valid,
  output logic                 pred_taken,
  output logic [IDX_BITS-1:0]  pred_index,
  input  logic                 update_valid,
  input  logic [IDX_BITS-1:0]  update_index,
  input  logic                 update_taken,
  input  logic                 ghr_clear,
  output logic [GHR_WIDTH-1:0] ghr
);

  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = {CTR_WIDTH{1'b1}};
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'(INIT_VALUE);

  // Counter storage is a plain flop array so every entry can be reset at once.
  logic [CTR_WIDTH-1:0] ctr [ENTRIES];

  logic [IDX_BITS-1:0]  pc_base;
  logic [IDX_BITS-1:0]  ghr_ext;
  logic [IDX_BITS-1:0]  lookup_idx;
  logic [CTR_WIDTH-1:0] upd_old;
  logic [CTR_WIDTH-1:0] upd_new;
  logic [CTR_WIDTH-1:0] lookup_ctr;
  logic [GHR_WIDTH-1:0] ghr_shift;
  logic                 unused_pc;

  // Word-aligned PC bits select the entry; the low two and the upper bits are don't-care.
  assign pc_base   = lookup_pc[IDX_BITS+1:2];
  assign unused_pc = &{1'b0, lookup_pc[1:0], lookup_pc[PC_WIDTH-1:IDX_BITS+2]};
  assign ghr_ext   = IDX_BITS'(ghr);

  // History shift register input; a one-bit history simply tracks the last outcome.
  generate
    if (GHR_WIDTH == 1) begin : g_ghr_one
      assign ghr_shift = update_taken;
    end else begin : g_ghr_multi
      assign ghr_shift = {ghr[GHR_WIDTH-2:0], update_taken};
    end
  endgenerate

  // Lookup index: bimodal uses the PC alone, gshare folds in the committed history.
  always_comb begin
    lookup_idx = pc_base;
    if (GSHARE != 0) begin
      lookup_idx = pc_base ^ ghr_ext;
    end
  end

  // Saturating next value for the entry being trained this cycle.
  always_comb begin
    upd_old = ctr[update_index];
    upd_new = upd_old;
    if (update_taken) begin
      if (upd_old != CTR_MAX) begin
        upd_new = upd_old + 1'b1;
      end
    end else begin
      if (upd_old != '0) begin
        upd_new = upd_old - 1'b1;
      end
    end
  end

  // Read path with bypass so a same-cycle update to the looked-up entry is visible.
  always_comb begin
    lookup_ctr = ctr[lookup_idx];
    if (update_valid && (update_index == lookup_idx)) begin
      lookup_ctr = upd_new;
    end
  end

  // Counter array: async reset to the initial state, one trained entry per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i] <= CTR_INIT;
      end
    end else if (update_valid) begin
      ctr[update_index] <= upd_new;
    end
  end

  // Committed global history: clear wins over the resolve-time shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr <= '0;
    end else if (ghr_clear) begin
      ghr <= '0;
    end else if (update_valid) begin
      ghr <= ghr_shift;
    end
  end

  // Prediction register: valid pulses per lookup, taken/index hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_index <= '0;
    end else begin
      pred_valid <= lookup_valid;
      if (lookup_valid) begin
        pred_taken <= lookup_ctr[CTR_WIDTH-1];
        pred_index <= lookup_idx;
      end
    end
  end

endmodule

// File: tb/tb_branch_pht.sv
// tb/tb_branch_pht.sv - self-checking bench for branch_pht across four parameter sets
module tb_branch_pht;

  logic        clk;
  logic        reset;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        update_valid;
  logic [5:0]  update_index;
  logic        update_taken;
  logic        ghr_clear;

  logic [3:0]      pv;
  logic [3:0]      pt;
  logic [3:0][5:0] pidx;
  logic [3:0][5:0] gh;

  // d0: bimodal 2-bit, d1: gshare 2-bit, d2: bimodal 1-bit, d3: bimodal 3-bit init 4
  int CW[4]   = '{2, 2, 1, 3};
  int INIT[4] = '{1, 1, 0, 4};
  int GS[4]   = '{0, 1, 0, 0};

  int m_ctr[4][64];
  int m_ghr;
  int m_pv[4];
  int m_pt[4];
  int m_idx[4];

  int n_assert;
  int n_fail;

  branch_pht #(.PC_WIDTH(32), .ENTRIES(64), .CTR_WIDTH(2), .INIT_VALUE(1), .GSHARE(0), .GHR_WIDTH(6)) dut0 (
    .clk(clk), .reset(reset), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pv[0]), .pred_taken(pt[0]), .pred_index(pidx[0]),
    .update_valid(update_valid), .update_index(update_index), .update_taken(update_taken),
    .ghr_clear(ghr_clear), .ghr(gh[0]));

  branch_pht #(.PC_WIDTH(32), .ENTRIES(64), .CTR_WIDTH(2), .INIT_VALUE(1), .GSHARE(1), .GHR_WIDTH(6)) dut1 (
    .clk(clk), .reset(reset), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pv[1]), .pred_taken(pt[1]), .pred_index(pidx[1]),
    .update_valid(update_valid), .update_index(update_index), .update_taken(update_taken),
    .ghr_clear(ghr_clear), .ghr(gh[1]));

  branch_pht #(.PC_WIDTH(32), .ENTRIES(64), .CTR_WIDTH(1), .INIT_VALUE(0), .GSHARE(0), .GHR_WIDTH(6)) dut2 (
    .clk(clk), .reset(reset), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pv[2]), .pred_taken(pt[2]), .pred_index(pidx[2]),
    .update_valid(update_valid), .update_index(update_index), .update_taken(update_taken),
    .ghr_clear(ghr_clear), .ghr(gh[2]));

  branch_pht #(.PC_WIDTH(32), .ENTRIES(64), .CTR_WIDTH(3), .INIT_VALUE(4), .GSHARE(0), .GHR_WIDTH(6)) dut3 (
    .clk(clk), .reset(reset), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pv[3]), .pred_taken(pt[3]), .pred_index(pidx[3]),
    .update_valid(update_valid), .update_index(update_index), .update_taken(update_taken),
    .ghr_clear(ghr_clear), .ghr(gh[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < 64; i++) m_ctr[d][i] = INIT[d];
      m_pv[d]  = 0;
      m_pt[d]  = 0;
      m_idx[d] = 0;
    end
    m_ghr = 0;
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s d%0d pred_valid", tag, d), 32'(pv[d]), 32'(m_pv[d]));
      chk($sformatf("%s d%0d pred_taken", tag, d), 32'(pt[d]), 32'(m_pt[d]));
      chk($sformatf("%s d%0d pred_index", tag, d), 32'(pidx[d]), 32'(m_idx[d]));
      chk($sformatf("%s d%0d ghr", tag, d), 32'(gh[d]), 32'(m_ghr));
    end
  endtask

  // One clock of stimulus; the model applies the spec rules in plain arithmetic.
  task automatic step(input string tag, input bit lv, input logic [31:0] pc,
                      input bit uv, input int uidx, input bit ut, input bit gc);
    int idx[4];
    lookup_valid = lv;
    lookup_pc    = pc;
    update_valid = uv;
    update_index = 6'(uidx);
    update_taken = ut;
    ghr_clear    = gc;
    for (int d = 0; d < 4; d++) begin
      idx[d] = (int'(pc >> 2) % 64) ^ (GS[d] != 0 ? m_ghr : 0);
      if (uv) begin
        if (ut) m_ctr[d][uidx] = (m_ctr[d][uidx] + 1 > (1 << CW[d]) - 1) ? (1 << CW[d]) - 1 : m_ctr[d][uidx] + 1;
        else    m_ctr[d][uidx] = (m_ctr[d][uidx] - 1 < 0) ? 0 : m_ctr[d][uidx] - 1;
      end
      if (lv) begin
        m_pv[d]  = 1;
        m_idx[d] = idx[d];
        m_pt[d]  = (m_ctr[d][idx[d]] >= (1 << (CW[d] - 1))) ? 1 : 0;
      end else begin
        m_pv[d] = 0;
      end
    end
    if (gc) m_ghr = 0;
    else if (uv) m_ghr = ((m_ghr * 2) + (ut ? 1 : 0)) % 64;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset = 1'b1;
    lookup_valid = 1'b0;
    lookup_pc = '0;
    update_valid = 1'b0;
    update_index = '0;
    update_taken = 1'b0;
    ghr_clear = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    reset = 1'b0;

    // first lookup after reset
    step("rst_lookup", 1, 32'h100, 0, 0, 0, 0);
    chk("rst_lookup pred_index", 32'(pidx[0]), 32'd0);
    chk("rst_lookup pred_taken", 32'(pt[0]), 32'd0);

    // saturation up then down on entry 0
    for (int i = 0; i < 4; i++) step("sat_up", 0, 0, 1, 0, 1, 0);
    step("sat_up_lookup", 1, 32'h0, 0, 0, 0, 0);
    chk("sat_up pred_taken", 32'(pt[0]), 32'd1);
    for (int i = 0; i < 5; i++) step("sat_dn", 0, 0, 1, 0, 0, 0);
    step("sat_dn_lookup", 1, 32'h0, 0, 0, 0, 0);
    chk("sat_dn pred_taken", 32'(pt[0]), 32'd0);

    // idle lookup: valid drops, taken/index hold
    step("idle", 0, 32'h44, 0, 0, 0, 0);

    // write-to-read bypass on entry 5
    step("bypass", 1, 32'h14, 1, 5, 1, 0);
    chk("bypass pred_taken", 32'(pt[0]), 32'd1);

    // gshare indexing with a known history
    step("gs_clr", 0, 0, 0, 0, 0, 1);
    step("gs_t1", 0, 0, 1, 40, 1, 0);
    step("gs_t2", 0, 0, 1, 40, 1, 0);
    step("gs_n3", 0, 0, 1, 41, 0, 0);
    chk("gs ghr", 32'(gh[1]), 32'd6);
    step("gs_lookup", 1, 32'h40, 0, 0, 0, 0);
    chk("gs pred_index", 32'(pidx[1]), 32'd22);

    // clear beats the shift, counter still trains, lookup uses pre-clear history
    step("gs_clr_upd", 1, 32'h40, 1, 22, 1, 1);
    chk("clr ghr", 32'(gh[1]), 32'd0);

    // 1-bit and 3-bit saturation
    for (int i = 0; i < 9; i++) step("w_up", 0, 0, 1, 3, 1, 0);
    step("w_up_lookup", 1, 32'hC, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step("w_dn", 0, 0, 1, 3, 0, 0);
    step("w_dn_lookup", 1, 32'hC, 0, 0, 0, 0);
    step("w_one_up", 1, 32'hC, 1, 3, 1, 0);

    // randomized traffic with frequent index collisions
    for (int n = 0; n < 400; n++) begin
      logic [31:0] rpc;
      int ridx;
      rpc  = $urandom;
      ridx = ($urandom_range(0, 1) == 0) ? int'(rpc >> 2) % 64 : int'($urandom_range(0, 63));
      step("rand", ($urandom_range(0, 3) != 0), rpc, $urandom_range(0, 1) == 1, ridx,
           $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
    end

    // asynchronous reset while a prediction is outstanding
    step("pre_rst", 1, 32'h28, 1, 10, 1, 0);
    lookup_valid = 1'b1;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    reset = 1'b0;
    step("post_rst_a", 1, 32'h28, 0, 0, 0, 0);
    step("post_rst_b", 1, 32'h0, 0, 0, 0, 0);
    step("post_rst_c", 1, 32'hC, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
